// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU load/store port: accepts one word request at a
// time, performs it after a fixed latency, and returns data/ack over a response handshake.
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [31:0]   addr_reg, addr_next;
    logic [31:0]   wdata_reg, wdata_next;
    logic          write_reg, write_next;
    logic          err_reg, err_next;
    logic          load_ok_reg, load_ok_next;
    logic [31:0]   mem_rdata_reg;

    logic [31:0]   mem_array [DEPTH];
    logic [AW-1:0] word_idx;
    logic          addr_bad;
    logic          access;

    assign word_idx = addr_reg[AW+1:2];
    assign addr_bad = (addr_reg[1:0] != 2'b00) || ((addr_reg >> (AW + 2)) != 32'd0);
    assign access   = (state_reg == BUSY) && (cnt_reg == '0);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        write_next   = write_reg;
        err_next     = err_reg;
        load_ok_next = load_ok_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    addr_next  = req_addr;
                    wdata_next = req_wdata;
                    write_next = req_write;
                    cnt_next   = CNT_LOAD;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CW'(1);
                end else begin
                    err_next     = addr_bad;
                    load_ok_next = !write_reg && !addr_bad;
                    state_next   = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    err_next     = 1'b0;
                    load_ok_next = 1'b0;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            write_reg   <= 1'b0;
            err_reg     <= 1'b0;
            load_ok_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            write_reg   <= write_next;
            err_reg     <= err_next;
            load_ok_reg <= load_ok_next;
        end
    end

    // Array port is unreset; the async reset already pulls state out of BUSY, so an
    // abandoned access never fires.
    always_ff @(posedge clk) begin
        if (access) begin
            if (write_reg && !addr_bad) begin
                mem_array[word_idx] <= wdata_reg;
            end
            mem_rdata_reg <= mem_array[word_idx];
        end
    end

    assign req_ready  = (state_reg == IDLE) && !reset;
    assign resp_valid = (state_reg == RESP);
    assign resp_err   = err_reg;
    assign resp_rdata = load_ok_reg ? mem_rdata_reg : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, multi-cycle corner sequences and
// randomized traffic against a word-level memory model.
module tb_dmem_responder;

    localparam int DEPTH   = 1024;
    localparam int LATENCY = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [31:0] model_mem [int];

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_write  (req_write),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset && req_ready && resp_valid) begin
            miscompares++;
            $display("FAIL ready_and_valid: req_ready=1 resp_valid=1 at cycle %0d, required not both", cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endfunction

    function automatic logic addr_err(logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
    endfunction

    // One full request/response transaction with latency, stability and drop checks.
    task automatic txn(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_er, input bit chk_rd,
                       input int hold);
        int guard;
        int lat;
        logic [31:0] rd;
        logic er;
        @(negedge clk);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_write  = wr;
        req_wdata  = wd;
        resp_ready = (hold == 0);
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_write = 1'($urandom);
        lat = 0;
        while (!resp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(LATENCY));
        rd = resp_rdata;
        er = resp_err;
        if (chk_rd) chk("rdata", rd, exp_rd);
        chk("err", 32'(er), 32'(exp_er));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_rdata", resp_rdata, rd);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("drop_valid", 32'(resp_valid), 32'd0);
        chk("drop_req_ready", 32'(req_ready), 32'd1);
        chk("drop_rdata", resp_rdata, 32'd0);
        chk("drop_err", 32'(resp_err), 32'd0);
        $display("txn %s addr=%h wdata=%h rdata=%h err=%b lat=%0d hold=%0d",
                 wr ? "ST" : "LD", addr, wd, rd, er, lat, hold);
    endtask

    // Transaction whose expectation comes from the word-level model.
    task automatic model_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                             input int hold);
        logic        e;
        logic [31:0] exp_rd;
        bit          known;
        int          w;
        e = addr_err(addr);
        w = int'(addr >> 2);
        known = 1'b1;
        exp_rd = 32'd0;
        if (!wr && !e) begin
            known = model_mem.exists(w);
            if (known) exp_rd = model_mem[w];
        end
        txn(addr, wr, wd, exp_rd, e, known, hold);
        if (wr && !e) model_mem[w] = wd;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          hold;
    } vec_t;

    vec_t table_v [12];
    int   acc [3];
    bit   seen;
    int   guard;
    int   n;
    logic [31:0] ra;
    logic [31:0] b2b_data [3];

    initial begin
        table_v[0]  = '{32'h10,       1'b1, 32'hDEADBEEF, 32'h0,        1'b0, 0};
        table_v[1]  = '{32'h10,       1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 0};
        table_v[2]  = '{32'h12,       1'b1, 32'h1,        32'h0,        1'b1, 0};
        table_v[3]  = '{32'h10,       1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 0};
        table_v[4]  = '{32'h1000,     1'b0, 32'h0,        32'h0,        1'b1, 0};
        table_v[5]  = '{32'hFFC,      1'b1, 32'h12345678, 32'h0,        1'b0, 0};
        table_v[6]  = '{32'hFFC,      1'b0, 32'h0,        32'h12345678, 1'b0, 0};
        table_v[7]  = '{32'h10,       1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 5};
        table_v[8]  = '{32'h20,       1'b1, 32'h11111111, 32'h0,        1'b0, 0};
        table_v[9]  = '{32'hFFFFFFFC, 1'b0, 32'h0,        32'h0,        1'b1, 2};
        table_v[10] = '{32'h3,        1'b0, 32'h0,        32'h0,        1'b1, 0};
        table_v[11] = '{32'h1000,     1'b1, 32'h5555AAAA, 32'h0,        1'b1, 1};

        // Reset state
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            txn(table_v[i].addr, table_v[i].write, table_v[i].wdata,
                table_v[i].exp_rdata, table_v[i].exp_err, 1'b1, table_v[i].hold);
            if (table_v[i].write && !table_v[i].exp_err)
                model_mem[int'(table_v[i].addr >> 2)] = table_v[i].wdata;
        end

        // Reset in BUSY abandons a store of 0xCAFEF00D over 0x11111111
        @(negedge clk);
        req_valid  = 1'b1;
        req_addr   = 32'h20;
        req_write  = 1'b1;
        req_wdata  = 32'hCAFEF00D;
        resp_ready = 1'b1;
        chk("midrst_pre_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen = 1'b1;
        end
        chk("midrst_no_resp", 32'(seen), 32'd0);
        chk("midrst_ready_after", 32'(req_ready), 32'd1);
        $display("txn RST abandoned store addr=00000020 wdata=cafef00d");
        model_txn(32'h20, 1'b0, 32'h0, 0);

        // Back-to-back stores with req_valid held high
        b2b_data[0] = 32'hA0A0A0A0;
        b2b_data[1] = 32'hB1B1B1B1;
        b2b_data[2] = 32'hC2C2C2C2;
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0;
        req_wdata = b2b_data[0];
        n = 0;
        guard = 0;
        while (n < 3 && guard < 100) begin
            if (req_ready) begin
                @(posedge clk);
                #1;
                acc[n] = cyc;
                n++;
                if (n < 3) begin
                    req_addr  = 32'(4 * n);
                    req_wdata = b2b_data[n];
                end
            end
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b0;
        chk("b2b_accepts", 32'(n), 32'd3);
        if (n == 3) begin
            chk("b2b_gap01", 32'(acc[1] - acc[0]), 32'(LATENCY + 2));
            chk("b2b_gap12", 32'(acc[2] - acc[1]), 32'(LATENCY + 2));
            $display("txn B2B accepts at cycles %0d %0d %0d", acc[0], acc[1], acc[2]);
        end
        repeat (LATENCY + 3) @(posedge clk);
        for (int i = 0; i < 3; i++) model_mem[i] = b2b_data[i];
        for (int i = 0; i < 3; i++) model_txn(32'(4 * i), 1'b0, 32'h0, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0:       ra = {$urandom_range(0, 63), 2'b00} | 32'($urandom_range(1, 3));
                1:       ra = 32'(4 * DEPTH) + {$urandom_range(0, 4095), 2'b00};
                2:       ra = 32'(4 * DEPTH - 4);
                default: ra = {$urandom_range(0, 63), 2'b00};
            endcase
            model_txn(ra, 1'($urandom), $urandom, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
